// File: rtl/bcd_seq_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3), W shift cycles per value.
// Optional seven-segment outputs seg_tens/seg_units are enabled with macro SEG7_EN.
module bcd_seq_conv #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_b,
    input  logic         in_valid,
    input  logic [W-1:0] bin,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [3:0]   tens,
    output logic [3:0]   units,
    output logic [3:0]   msd
`ifdef SEG7_EN
    ,
    output logic [6:0]   seg_tens,
    output logic [6:0]   seg_units
`endif
);

    // state | meaning
    // IDLE  | waiting for in_valid; last result held on the digit outputs
    // SHIFT | add-3 / shift loop, cnt counts remaining shift cycles
    // DONE  | result presented, waiting for out_ready

    localparam int CW = $clog2(W + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   binreg;
    logic [2:0]     tens_lo;
    logic [3:0]     units_adj;

    always_ff @(posedge clk) begin
        if (!rst_b) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid) state_nxt = SHIFT;
            SHIFT:   if (cnt == CW'(1)) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Only the low three bits of the adjusted tens survive the shift.
    assign tens_lo   = 3'((tens >= 4'd5) ? tens + 4'd3 : tens);
    assign units_adj = (units >= 4'd5) ? units + 4'd3 : units;

    always_ff @(posedge clk) begin
        if (!rst_b) begin
            tens   <= '0;
            units  <= '0;
            binreg <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    binreg <= bin;
                    tens   <= '0;
                    units  <= '0;
                    cnt    <= CW'(W);
                end
                SHIFT: begin
                    {tens, units, binreg} <= {tens_lo, units_adj, binreg, 1'b0};
                    cnt <= cnt - CW'(1);
                end
                default: ;
            endcase
        end
    end

    // A nonzero tens digit means the value is at least ten.
    assign msd = (tens != 4'd0) ? tens : units;

`ifdef SEG7_EN
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0111111;
            4'd1:    seg7 = 7'b0000110;
            4'd2:    seg7 = 7'b1011011;
            4'd3:    seg7 = 7'b1001111;
            4'd4:    seg7 = 7'b1100110;
            4'd5:    seg7 = 7'b1101101;
            4'd6:    seg7 = 7'b1111101;
            4'd7:    seg7 = 7'b0000111;
            4'd8:    seg7 = 7'b1111111;
            4'd9:    seg7 = 7'b1101111;
            default: seg7 = 7'b0000000;
        endcase
    endfunction

    assign seg_tens  = rst_b ? seg7(tens)  : 7'b0000000;
    assign seg_units = rst_b ? seg7(units) : 7'b0000000;
`endif

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Randomized and directed bench for bcd_seq_conv (W=5) against a decimal-arithmetic model.
// Define SEG7_EN to also check the seven-segment outputs.
module tb_bcd_seq_conv;
    localparam int W = 5;

    logic         clk = 1'b0;
    logic         rst_b;
    logic         in_valid;
    logic [W-1:0] bin;
    logic         in_ready;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   tens, units, msd;
`ifdef SEG7_EN
    logic [6:0]   seg_tens, seg_units;
    logic [6:0]   seg_lut [10];
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    bcd_seq_conv #(.W(W)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .in_valid  (in_valid),
        .bin       (bin),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .tens      (tens),
        .units     (units),
        .msd       (msd)
`ifdef SEG7_EN
        ,
        .seg_tens  (seg_tens),
        .seg_units (seg_units)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("ready_wait", in_ready, 1);
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!out_valid && k < 30) begin
            tick();
            k++;
            bin      = W'($urandom);
            in_valid = 1'($urandom);
        end
    endtask

    task automatic check_digits(input string tag, input int v);
        int et, eu;
        et = v / 10;
        eu = v % 10;
        check({tag, "_tens"}, tens, et);
        check({tag, "_units"}, units, eu);
        check({tag, "_msd"}, msd, (v >= 10) ? et : eu);
`ifdef SEG7_EN
        check({tag, "_segt"}, seg_tens, seg_lut[et]);
        check({tag, "_segu"}, seg_units, seg_lut[eu]);
`endif
    endtask

    task automatic xfer(input int v, input int stall);
        int k;
        wait_ready();
        in_valid  = 1'b1;
        bin       = W'(v);
        out_ready = (stall == 0);
        tick();
        in_valid = 1'b0;
        bin      = W'($urandom);
        wait_valid(k);
        check("latency", k, W);
        check_digits("result", v);
        for (int s = 0; s < stall; s++) begin
            in_valid = 1'b1;
            bin      = W'($urandom);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_ready", in_ready, 0);
            check_digits("hold", v);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("consume_ready", in_ready, 1);
        check("consume_valid", out_valid, 0);
        check_digits("retain", v);
    endtask

    initial begin
        int k, prev, seen;
`ifdef SEG7_EN
        seg_lut = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
                    7'b1101101, 7'b1111101, 7'b0000111, 7'b1111111, 7'b1101111};
`endif
        rst_b     = 1'b0;
        in_valid  = 1'b0;
        bin       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_tens", tens, 0);
        check("rst_units", units, 0);
        check("rst_msd", msd, 0);
`ifdef SEG7_EN
        check("rst_segt", seg_tens, 0);
        check("rst_segu", seg_units, 0);
`endif
        rst_b = 1'b1;
        tick();

        xfer(0, 0);
        xfer(31, 0);
        xfer(9, 0);
        xfer(10, 0);
        xfer(28, 0);
`ifdef SEG7_EN
        check("seg28_tens", seg_tens, 7'b1011011);
        check("seg28_units", seg_units, 7'b1111111);
`endif
        xfer(27, 20);

        // back-to-back sweep with in_valid held high
        in_valid  = 1'b1;
        out_ready = 1'b1;
        prev      = 0;
        for (int v = 0; v < 32; v++) begin
            wait_ready();
            in_valid = 1'b1;
            bin      = W'(v);
            if (v > 0) check("span", cyc - prev, W + 2);
            prev = cyc;
            tick();
            bin = W'($urandom);
            k = 0;
            while (!out_valid && k < 30) begin
                tick();
                k++;
                bin = W'($urandom);
            end
            check("sweep_latency", k, W);
            check_digits("sweep", v);
        end
        in_valid = 1'b0;
        tick();

        for (int i = 0; i < 30; i++)
            xfer(int'($urandom_range(0, 31)), int'($urandom_range(0, 3)));

        // reset on the third shift cycle aborts the conversion
        wait_ready();
        in_valid  = 1'b1;
        bin       = W'(27);
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst_b = 1'b0;
        tick();
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_tens", tens, 0);
        check("abort_units", units, 0);
        check("abort_msd", msd, 0);
        rst_b = 1'b1;
        seen  = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("abort_no_result", seen, 0);

        xfer(63 % 32, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bcd_seq_conv.md
BCD_SEQ_CONV -- requirements
Module: bcd_seq_conv

Interface
REQ-001 The block SHALL take parameter W, default 5: width of the binary input; legal range 1..6, so the maximum value is 63 and two BCD digits always suffice.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_b, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: upstream offers bin.
REQ-005 The block SHALL have port bin, input, W bits: unsigned binary value to convert.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept bin.
REQ-007 The block SHALL have port out_valid, output, 1 bit: tens, units and msd are valid.
REQ-008 The block SHALL have port out_ready, input, 1 bit: downstream consumes the result.
REQ-009 The block SHALL have port tens, output, 4 bits: BCD tens digit.
REQ-010 The block SHALL have port units, output, 4 bits: BCD units digit.
REQ-011 The block SHALL have port msd, output, 4 bits: most significant decimal digit, equal to tens when value >= 10, otherwise equal to units.

Function
REQ-012 The FSM SHALL have exactly three states, IDLE, SHIFT and DONE, with these transitions:
- IDLE to SHIFT on in_valid && in_ready;
- SHIFT to DONE after exactly W shift cycles;
- DONE to IDLE on out_ready.
REQ-013 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE; they are never both high.
REQ-014 On the accept edge the block SHALL capture bin into a W-bit shift register, clear both BCD nibbles and load a cycle counter with W.
REQ-015 Each SHIFT cycle SHALL:
- first add 3 to every BCD nibble whose value is >= 5;
- then shift {tens, units, binreg} left by one bit;
- then decrement the counter.
REQ-016 out_valid SHALL assert exactly W rising edges after the accept edge; the latency is W cycles, independent of the value.
REQ-017 tens, units and msd SHALL hold stable while out_valid=1 and out_ready=0, for any number of cycles.
REQ-018 If out_ready is already 1 when DONE is entered, the result SHALL be consumed after one cycle of out_valid; the next accept occurs no earlier than the following edge, so one transfer takes W+2 cycles minimum.
REQ-019 bin and in_valid SHALL be ignored outside IDLE; a value changed during SHIFT SHALL NOT affect the result.
REQ-020 Digit ranges SHALL be: tens in 0..6, units in 0..9; no value outside 0..9 SHALL ever appear on tens, units or msd in DONE.
REQ-021 tens, units and msd SHALL retain the last converted result in IDLE; they update only as a result of shifting.

Reset
REQ-022 While rst_b=0 at a rising edge, the block SHALL enter IDLE and clear all of the following:
- in_ready to 1;
- out_valid to 0;
- tens, units and msd to 0;
- the counter and the shift register to 0.
REQ-023 Reset asserted during SHIFT or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted value.

Configuration
REQ-024 With macro SEG7_EN defined, the block SHALL add two output ports:
- seg_tens, 7 bits;
- seg_units, 7 bits.
Both are active-high, bit order gfedcba (bit0 = a), decoded combinationally from tens and units, and 0000000 under reset.
REQ-025 Without SEG7_EN, seg_tens and seg_units SHALL NOT exist, and all other behaviour SHALL be identical.

Verification
REQ-026 The bench SHALL cover these directed scenarios (W=5):
- bin=0, in_valid one cycle, out_ready=1 -> out_valid after 5 edges, tens=0 units=0 msd=0.
- bin=31 -> tens=3 units=1 msd=3; bin=9 -> tens=0 units=9 msd=9; bin=10 -> tens=1 units=0 msd=1.
- Sweep bin 0..31 back-to-back with out_ready=1 -> every result matches value/10 and value%10, msd per REQ-011, and each transfer spans 7 cycles.
- out_ready=0 for 20 cycles in DONE -> out_valid stays 1 and the digits are unchanged; in_ready stays 0 and a new bin is ignored.
- rst_b=0 on the third SHIFT cycle of bin=27 -> next edge shows IDLE, in_ready=1, out_valid=0, digits=0, and no result is ever produced.
- With SEG7_EN, bin=28 -> seg_tens=1011011, seg_units=1111111.
